scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder_pkg.sv | 9 +
 rtl/scan_decoder_if.sv | 19 +
 rtl/one_hot_dec_n.sv | 10 +
 rtl/scan_decoder.sv | 50 +++++
 tb/tb_scan_decoder.sv | 121 ++++++++++++
 5 files changed

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: scan mode encodings shared by the decoder, its interface and benches
package scan_decoder_pkg;
   typedef enum logic [1:0] {
      MODE_DIRECT  = 2'b00,
      MODE_SCAN_UP = 2'b01,
      MODE_SCAN_DN = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_t;
endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control and decode bus of scan_decoder
// master drives g_n, mode, sel, load, dwell; slave drives dec_out_n, index, wrap
interface scan_decoder_if #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
);
   import scan_decoder_pkg::*;
   localparam int OUT_W = 2**SEL_W;
   logic               g_n;
   mode_t              mode;
   logic [SEL_W-1:0]   sel;
   logic               load;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   dec_out_n;
   logic [SEL_W-1:0]   index;
   logic               wrap;
   modport master (output g_n, mode, sel, load, dwell, input dec_out_n, index, wrap);
   modport slave  (input g_n, mode, sel, load, dwell, output dec_out_n, index, wrap);
endinterface

// File: rtl/one_hot_dec_n.sv
// one_hot_dec_n: combinational active-low one-hot decoder, index k pulls bit OUT_W-1-k low
// sel: index in; dec_n: active-low decode out (no enable)
module one_hot_dec_n #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]    sel,
   output logic [2**SEL_W-1:0] dec_n
);
   assign dec_n = ~({1'b1, {(2**SEL_W-1){1'b0}}} >> sel);
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered active-low decoder with direct, scanning and hold modes
// clk, rst_n (async, active-low); bus.slave: g_n/mode/sel/load/dwell in, dec_out_n/index/wrap out
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input logic           clk,
   input logic           rst_n,
   scan_decoder_if.slave bus
);
   localparam int OUT_W = 2**SEL_W;
   logic [SEL_W-1:0]   idx, idx_n;
   logic [DWELL_W-1:0] cnt, cnt_n;
   logic [OUT_W-1:0]   dec, dec_q;
   mode_t              prev_mode;
   logic               wrap_q, wrap_n, mode_chg, scan, up, due;
   // cnt >= dwell (not ==) so a dwell lowered below the running count steps at once
   always_comb begin
      mode_chg = bus.mode != prev_mode;
      scan     = bus.mode == MODE_SCAN_UP || bus.mode == MODE_SCAN_DN;
      up       = bus.mode == MODE_SCAN_UP;
      due      = !bus.load && !mode_chg && !bus.g_n && scan && cnt >= bus.dwell;
      idx_n    = bus.load ? bus.sel : due ? (up ? idx + SEL_W'(1) : idx - SEL_W'(1)) : idx;
      cnt_n    = (bus.load || mode_chg || due) ? '0 :
                 (bus.g_n || bus.mode == MODE_HOLD) ? cnt :
                 scan ? cnt + DWELL_W'(1) : '0;
      wrap_n   = due && (up ? idx == '1 : idx == '0);
   end
   one_hot_dec_n #(.SEL_W(SEL_W)) u_dec (.sel(idx_n), .dec_n(dec));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         cnt       <= '0;
         prev_mode <= MODE_DIRECT;
         wrap_q    <= 1'b0;
         dec_q     <= '1;
      end else begin
         idx       <= idx_n;
         cnt       <= cnt_n;
         prev_mode <= bus.mode;
         wrap_q    <= wrap_n;
         dec_q     <= bus.g_n ? '1 : dec;
      end
   end
   assign bus.index     = idx;
   assign bus.dec_out_n = dec_q;
   assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed scoreboard bench for scan_decoder (SEL_W=3, DWELL_W=8)
module tb_scan_decoder;
   import scan_decoder_pkg::*;
   typedef struct {
      int         tag;
      logic [2:0] idx;
      logic [7:0] dec;
      logic       wrap;
   } exp_t;
   logic clk, rst_n;
   int   tests, fails, n;
   exp_t q[$];
   scan_decoder_if #(.SEL_W(3), .DWELL_W(8)) bus ();
   scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [7:0] dec_of(input logic [2:0] k);
      logic [7:0] v;
      v = 8'h80 >> k;
      return ~v;
   endfunction
   task automatic check(input string name, input logic [2:0] ei, input logic [7:0] ed, input logic ew);
      tests++;
      if (bus.index !== ei || bus.dec_out_n !== ed || bus.wrap !== ew) begin
         fails++;
         $display("FAIL %s: got index=%0d dec_out_n=%b wrap=%b, want index=%0d dec_out_n=%b wrap=%b",
                  name, bus.index, bus.dec_out_n, bus.wrap, ei, ed, ew);
      end
   endtask
   task automatic cyc(input logic g, input logic [1:0] m, input logic [2:0] s, input logic l,
                      input logic [7:0] d, input logic [2:0] ei, input logic [7:0] ed, input logic ew);
      exp_t e;
      @(negedge clk);
      bus.g_n   = g;
      bus.mode  = mode_t'(m);
      bus.sel   = s;
      bus.load  = l;
      bus.dwell = d;
      e.tag  = n++;
      e.idx  = ei;
      e.dec  = ed;
      e.wrap = ew;
      q.push_back(e);
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check($sformatf("cycle%0d", e.tag), e.idx, e.dec, e.wrap);
      end
   end
   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish, got running, want finished");
      $fatal(1);
   end
   initial begin
      tests = 0;
      fails = 0;
      n     = 0;
      rst_n = 1'b0;
      bus.g_n = 1'b1;
      bus.mode = MODE_DIRECT;
      bus.sel = '0;
      bus.load = 1'b0;
      bus.dwell = '0;
      #12;
      check("reset", 3'd0, 8'hFF, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 2'b00, 3'd0, 0, 8'd0, 3'd0, 8'h7F, 0);
      cyc(0, 2'b00, 3'd5, 1, 8'd0, 3'd5, 8'b11111011, 0);
      repeat (10) cyc(0, 2'b00, 3'd5, 0, 8'd0, 3'd5, 8'b11111011, 0);
      cyc(0, 2'b01, 3'd6, 1, 8'd0, 3'd6, dec_of(3'd6), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd7, dec_of(3'd7), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd0, 8'h7F, 1);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd1, dec_of(3'd1), 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd1, dec_of(3'd1), 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd1, dec_of(3'd1), 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd1, dec_of(3'd1), 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd0, 8'h7F, 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd0, 8'h7F, 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd0, 8'h7F, 0);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd7, 8'b11111110, 1);
      cyc(0, 2'b10, 3'd0, 0, 8'd2, 3'd7, 8'b11111110, 0);
      cyc(0, 2'b01, 3'd3, 1, 8'd3, 3'd3, dec_of(3'd3), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd3, 3'd3, dec_of(3'd3), 0);
      repeat (4) cyc(1, 2'b01, 3'd0, 0, 8'd3, 3'd3, 8'hFF, 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd3, 3'd3, 8'b11101111, 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd3, 3'd3, 8'b11101111, 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd3, 3'd4, dec_of(3'd4), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd3, 3'd4, dec_of(3'd4), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd3, 3'd4, dec_of(3'd4), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd1, 3'd5, dec_of(3'd5), 0);
      repeat (3) cyc(0, 2'b11, 3'd0, 0, 8'd1, 3'd5, dec_of(3'd5), 0);
      cyc(0, 2'b01, 3'd7, 1, 8'd0, 3'd7, dec_of(3'd7), 0);
      cyc(0, 2'b01, 3'd2, 1, 8'd0, 3'd2, dec_of(3'd2), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd3, dec_of(3'd3), 0);
      cyc(1, 2'b01, 3'd6, 1, 8'd0, 3'd6, 8'hFF, 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd7, dec_of(3'd7), 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd0, 8'h7F, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", 3'd0, 8'hFF, 1'b0);
      rst_n = 1'b1;
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd0, 8'h7F, 0);
      cyc(0, 2'b01, 3'd0, 0, 8'd0, 3'd1, dec_of(3'd1), 0);
      @(posedge clk);
      #2;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
